// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, FSM state type and op-classification helpers for mult_div_unit.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_iter(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction at operand latch
// and sign restoration of results.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional macro MDU_DIVZERO_EXC_EN: division by zero completes at once with div_zero.
//
// state    | meaning
// ST_IDLE  | waiting for start; MT* writes and ignored ops handled here
// ST_RUN   | one multiply/divide bit per cycle, WIDTH cycles
// ST_FIX   | sign correction and hi/lo write-back, done pulse
import mult_div_unit_pkg::*;

module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             op_div;
  logic             sgn_a;
  logic             sgn_b;
  logic             div_zero_r;
`ifndef MDU_DIVZERO_EXC_EN
  logic             div_by_zero;
`endif

  logic             neg_a;
  logic             neg_b;
  logic             b_zero;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign neg_a  = md_is_signed(md_op) & a[WIDTH-1];
  assign neg_b  = md_is_signed(md_op) & b[WIDTH-1];
  assign b_zero = (b == '0);

  md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.value(a), .neg(neg_a), .result(abs_a));
  md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.value(b), .neg(neg_b), .result(abs_b));

  // Multiply step: conditional add into the upper half, then shift the pair right.
  logic [WIDTH:0] mac_sum;
  assign mac_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // Restoring divide step: partial remainder in acc_hi, dividend/quotient in acc_lo.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic             unused_trial_msb;
  assign shifted          = {acc_hi, acc_lo[WIDTH-1]};
  assign trial            = shifted - {1'b0, opnd};
  assign fits             = (shifted >= {1'b0, opnd});
  assign unused_trial_msb = trial[WIDTH];

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value({acc_hi, acc_lo}), .neg(sgn_a ^ sgn_b), .result(prod_fixed));
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .value(acc_lo), .neg(sgn_a ^ sgn_b), .result(quo_fixed));
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .value(acc_hi), .neg(sgn_a), .result(rem_fixed));

  assign div_zero = div_zero_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      op_div      <= 1'b0;
      sgn_a       <= 1'b0;
      sgn_b       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_zero_r  <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifndef MDU_DIVZERO_EXC_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      div_zero_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (md_op == MD_MTHI) begin
              hi   <= a;
              done <= 1'b1;
            end else if (md_op == MD_MTLO) begin
              lo   <= a;
              done <= 1'b1;
            end else if (md_is_iter(md_op)) begin
`ifdef MDU_DIVZERO_EXC_EN
              if (md_is_div(md_op) && b_zero) begin
                done       <= 1'b1;
                div_zero_r <= 1'b1;
              end else begin
                op_div <= md_is_div(md_op);
                sgn_a  <= neg_a;
                sgn_b  <= neg_b;
                acc_hi <= '0;
                acc_lo <= abs_a;
                opnd   <= abs_b;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= ST_RUN;
              end
`else
              // A zero divisor keeps the raw dividend so it emerges unmodified as the remainder.
              div_by_zero <= md_is_div(md_op) && b_zero;
              op_div      <= md_is_div(md_op);
              sgn_a       <= neg_a;
              sgn_b       <= neg_b;
              acc_hi      <= '0;
              acc_lo      <= (md_is_div(md_op) && b_zero) ? a : abs_a;
              opnd        <= abs_b;
              cnt         <= '0;
              busy        <= 1'b1;
              state       <= ST_RUN;
`endif
            end
          end
        end

        ST_RUN: begin
          if (op_div) begin
            acc_hi <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], fits};
          end else begin
            acc_hi <= mac_sum[WIDTH:1];
            acc_lo <= {mac_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          if (op_div) begin
`ifndef MDU_DIVZERO_EXC_EN
            if (div_by_zero) begin
              hi <= acc_hi;
              lo <= acc_lo;
            end else begin
              hi <= rem_fixed;
              lo <= quo_fixed;
            end
`else
            hi <= rem_fixed;
            lo <= quo_fixed;
`endif
          end else begin
            {hi, lo} <= prod_fixed;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   md_op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: updates m_hi/m_lo and returns the cycle in which done is expected.
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int cyc, output logic dz);
    longint sx, sy, q, r;
    logic [63:0] p;
    cyc = W + 2;
    dz  = 1'b0;
    case (op)
      MD_MTHI: begin m_hi = x; cyc = 1; end
      MD_MTLO: begin m_lo = x; cyc = 1; end
      MD_MULT: begin
        p = 64'(longint'($signed(x)) * longint'($signed(y)));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      MD_MULTU: begin
        p = {32'b0, x} * {32'b0, y};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (y == 0) begin
`ifdef MDU_DIVZERO_EXC_EN
          cyc = 1; dz = 1'b1;
`else
          m_hi = x; m_lo = '1;
`endif
        end else if (op == MD_DIV) begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          q = sx / sy;
          r = sx % sy;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
      default: cyc = 0;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag);
    int exp_cyc, cyc, busy_cnt;
    logic exp_dz;
    model_op(op, x, y, exp_cyc, exp_dz);
    @(negedge clk);
    md_op = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check_val({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_cyc - 1));
    check_val({tag, " busy_at_done"}, 64'(busy), 64'(0));
    check_val({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    check_val({tag, " hi"}, 64'(hi), 64'(m_hi));
    check_val({tag, " lo"}, 64'(lo), 64'(m_lo));
    @(posedge clk); #1;
    check_val({tag, " done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, exp_cyc, done_seen;
    logic exp_dz;
    logic [2:0] op;
    logic [W-1:0] x, y;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rst busy", 64'(busy), 64'(0));
    check_val("rst done", 64'(done), 64'(0));
    check_val("rst div_zero", 64'(div_zero), 64'(0));
    check_val("rst hi", 64'(hi), 64'(0));
    check_val("rst lo", 64'(lo), 64'(0));

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check_val("multu_max hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check_val("multu_max lo_const", 64'(lo), 64'h1);
    run_op(MD_MULT, -32'sd3, 32'd5, "mult_neg");
    run_op(MD_DIV, -32'sd7, 32'd2, "div_neg");
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check_val("div_ovf lo_const", 64'(lo), 64'h8000_0000);
    run_op(MD_DIVU, 32'd100, 32'd7, "divu");
    run_op(MD_DIV, 32'h1234_5678, 32'd0, "div_zero");
    run_op(MD_DIVU, 32'h8765_4321, 32'd0, "divu_zero");
    run_op(MD_MTHI, 32'hCAFE_F00D, 32'd0, "mthi");
    run_op(MD_MTLO, 32'h1357_9BDF, 32'd0, "mtlo");

    // Unrecognised op: nothing happens.
    @(negedge clk);
    md_op = 3'd6; a = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("badop busy", 64'(busy), 64'(0));
    check_val("badop done", 64'(done), 64'(0));
    @(posedge clk); #1;
    check_val("badop done2", 64'(done), 64'(0));
    check_val("badop hi", 64'(hi), 64'(m_hi));
    check_val("badop lo", 64'(lo), 64'(m_lo));

    // Second start while busy is ignored.
    model_op(MD_MULTU, 32'h0001_2345, 32'h0006_789A, exp_cyc, exp_dz);
    @(negedge clk);
    md_op = MD_MULTU; a = 32'h0001_2345; b = 32'h0006_789A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    repeat (9) begin @(posedge clk); #1; cyc++; end
    md_op = MD_MTHI; a = 32'h5555_AAAA; b = 32'd9; start = 1'b1;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check_val("busy_start done_cycle", 64'(cyc), 64'(exp_cyc));
    check_val("busy_start hi", 64'(hi), 64'(m_hi));
    check_val("busy_start lo", 64'(lo), 64'(m_lo));

    // Reset mid-DIVU aborts with no done.
    @(negedge clk);
    md_op = MD_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("abort busy", 64'(busy), 64'(0));
    check_val("abort done", 64'(done), 64'(0));
    check_val("abort hi", 64'(hi), 64'(0));
    check_val("abort lo", 64'(lo), 64'(0));
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) done_seen++; end
    check_val("abort no_done", 64'(done_seen), 64'(0));
    run_op(MD_MULTU, 32'd6, 32'd7, "post_abort");
    check_val("post_abort lo_const", 64'(lo), 64'd42);

    // Random mix.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'd1;
        3: y = 32'($urandom_range(1, 255));
        4: begin y = 32'hFFFF_FFFF; x = 32'h8000_0000; end
        default: y = $urandom;
      endcase
      run_op(op, x, y, $sformatf("rnd%0d op%0d", i, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
